card_layout_ctrl: RTL and testbench
===================================

// Module: card_layout_ctrl
// PURPOSE
// Sequences the card position generator at game start. Triggers one position burst, captures the
// N streamed {y,x} positions into a local table, and flags a bad layout. Serves renderer read-back
// and mouse hit-tests, scanning the table one entry per cycle.
// Sits between the game FSM / mouse logic and cards_pos_gen.
// PARAMETERS
// MAX_CARDS  16  table depth (entries 0..15)
// NUM_W      5   width of card count / index fields
// POS_W      20  {y[19:10], x[9:0]} position width
// PORTS
// clk               in   1      system clock
// rst               in   1      synchronous reset, active-high
// load_start        in   1      1-cycle pulse: (re)load layout
// num_cards_in      in   NUM_W  card count for load (8, 12 or 16)
// read_all_positions out 1      to generator; 1-cycle start pulse
// num_of_cards      out  NUM_W  to generator; latched count, stable during burst
// yx_pos_in         in   POS_W  from generator yx_card_position
// layout_valid      out  1      table holds a complete layout
// load_done         out  1      1-cycle pulse at end of capture
// layout_err        out  1      sticky until next load: sentinel {1023,1023} captured, or bad count
// card_w, card_h    in   10     hit box size in pixels; sampled with hit_req
// hit_req           in   1      1-cycle pulse, accepted only in READY
// hit_x, hit_y      in   10     pointer coords; latched on accept
// hit_ack           out  1      1-cycle pulse: scan finished
// hit_found         out  1      valid with hit_ack
// hit_idx           out  NUM_W  matched entry; 0 on miss
// rd_idx            in   NUM_W  renderer read index
// rd_yx             out  POS_W  table[rd_idx], registered, 1-cycle latency; {1023,1023} if rd_idx>=count
// BEHAVIOUR
// - Reset: all outputs 0, except rd_yx = {1023,1023}. Table entries = {1023,1023}. State IDLE.
//   Reset mid-burst or mid-scan aborts at once; no ack or done is issued.
// - All outputs are registered. State machine:
//   IDLE:    on load_start with count 8/12/16: latch num_of_cards, clear layout_err, ->REQ.
//            On any other count: set layout_err, stay IDLE.
//   REQ:     read_all_positions=1 this cycle only, ->WAIT.
//   WAIT:    one cycle; matches the generator's IDLE->READ_ALL plus output-register latency. ->CAP.
//   CAP:     idx from 0. Each cycle: table[idx]<=yx_pos_in.
//            If yx_pos_in=={1023,1023}, set layout_err.
//            At idx==count-1: layout_valid<=1, load_done pulse, ->READY.
//            So positions i=0..N-1 are captured in the (2+i)th cycle after the REQ cycle.
//   READY:   load_start has priority over hit_req in the same cycle.
//            load_start: layout_valid<=0, then handled as in IDLE (bad count -> err, ->IDLE).
//            hit_req: latch hit_x, hit_y, card_w, card_h; i=0; ->SCAN.
//   SCAN:    one entry per cycle, i=0..count-1.
//            Match test: px<=hit_x<px+card_w and py<=hit_y<py+card_h.
//            Sums are 11 bits wide, so there is no wrap at 1023.
//            First match at i=k: hit_ack=1, hit_found=1, hit_idx=k, ->READY.
//            No match after i=count-1: hit_ack=1, hit_found=0, hit_idx=0, ->READY.
//            Latency: ack is registered k+1 cycles after the accept edge (miss: N cycles).
// - hit_req outside READY and load_start in REQ/WAIT/CAP/SCAN are ignored. No queueing.
// - Overlapping boxes: lowest index wins.
// - rd_yx works in every state. During CAP it returns the old or new entry per write order
//   (write first).
// TESTING
// 1 Easy load.
//   Stimulus: load_start, num=8.
//   Response: read_all_positions high exactly one cycle. load_done 10 cycles after pulse.
//   table[5]={418,308}; layout_err=0.
// 2 Hit.
//   Stimulus: in READY, hit_req x=320 y=430, card_w=200 card_h=300.
//   Response: hit_ack 6 cycles after accept, found=1, idx=5.
// 3 Miss.
//   Stimulus: hit x=10 y=10.
//   Response: hit_ack after 8 cycles, found=0, idx=0. A second hit_req during SCAN is dropped.
// 4 Hard boundary.
//   Stimulus: num=16, card_h=150. Hit x=824 y=550, then x=1023 y=700, then x=824 y=700.
//   Response: first -> idx 15, ack after 16 cycles. Second -> miss. Third (y = py+card_h) -> miss.
// 5 Errors.
//   Stimulus: num=10 -> layout_err=1, no read_all_positions.
//   Stimulus: generator forced to {1023,1023} on entry 3 -> layout_err=1, load still completes.
// 6 Reset and reload.
//   Stimulus: rst asserted in CAP at idx 4 -> all outputs and table reset, no load_done.
//   Stimulus: load_start num=12 in READY -> layout_valid low next cycle; reload completes, table[11]={518,824}.

Source files
------------

// File: rtl/card_layout_ctrl_if.sv
// Bundle between the layout controller and its game FSM / mouse / renderer / generator peers.
// slave = controller view, master = driver of loads, hits, reads and generator positions.
// No storage; pure wiring.
interface card_layout_ctrl_if #(
  parameter int NUM_W = 5,
  parameter int POS_W = 20
);
  logic             load_start;
  logic [NUM_W-1:0] num_cards_in;
  logic             read_all_positions;
  logic [NUM_W-1:0] num_of_cards;
  logic [POS_W-1:0] yx_pos_in;
  logic             layout_valid;
  logic             load_done;
  logic             layout_err;
  logic [9:0]       card_w;
  logic [9:0]       card_h;
  logic             hit_req;
  logic [9:0]       hit_x;
  logic [9:0]       hit_y;
  logic             hit_ack;
  logic             hit_found;
  logic [NUM_W-1:0] hit_idx;
  logic [NUM_W-1:0] rd_idx;
  logic [POS_W-1:0] rd_yx;

  modport slave (
    input  load_start, num_cards_in, yx_pos_in, card_w, card_h,
           hit_req, hit_x, hit_y, rd_idx,
    output read_all_positions, num_of_cards, layout_valid, load_done,
           layout_err, hit_ack, hit_found, hit_idx, rd_yx
  );

  modport master (
    output load_start, num_cards_in, yx_pos_in, card_w, card_h,
           hit_req, hit_x, hit_y, rd_idx,
    input  read_all_positions, num_of_cards, layout_valid, load_done,
           layout_err, hit_ack, hit_found, hit_idx, rd_yx
  );
endinterface

// File: rtl/card_layout_ctrl.sv
// Card layout controller: triggers one generator burst, captures N {y,x} positions, serves hit-tests and reads.
// Latency: load_done 2+N cycles after load_start; hit_ack k+1 cycles after accept (N on miss); rd_yx 1 cycle.
// No backpressure: requests outside their accepting state are dropped, never queued.
module card_layout_ctrl #(
  parameter int MAX_CARDS = 16,
  parameter int NUM_W     = 5,
  parameter int POS_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  card_layout_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_CARDS);
  // {1023,1023}: empty entry / generator error marker
  localparam logic [POS_W-1:0] SENT = '1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CAP, S_READY, S_SCAN} state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             rd_all_q, rd_all_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [9:0]       hx_q, hx_d, hy_q, hy_d, cw_q, cw_d, ch_q, ch_d;
  logic             ack_q, ack_d;
  logic             found_q, found_d;
  logic [NUM_W-1:0] hidx_q, hidx_d;
  logic [POS_W-1:0] rd_yx_q, rd_yx_d;
  logic [POS_W-1:0] pos_tbl_q [MAX_CARDS];

  logic             cap_we;
  logic             good_cnt;
  logic             load_go;
  logic [POS_W-1:0] scan_ent;
  logic [10:0]      px, py;
  logic             match;

  assign cap_we   = (state_q == S_CAP);
  assign good_cnt = (bus.num_cards_in == NUM_W'(8)) || (bus.num_cards_in == NUM_W'(12)) ||
                    (bus.num_cards_in == NUM_W'(16));
  assign scan_ent = pos_tbl_q[idx_q[IDX_W-1:0]];
  assign px       = {1'b0, scan_ent[9:0]};
  assign py       = {1'b0, scan_ent[19:10]};
  // 11-bit sums so a box reaching past x/y=1023 does not wrap to zero
  assign match    = (px <= {1'b0, hx_q}) && ({1'b0, hx_q} < px + {1'b0, cw_q}) &&
                    (py <= {1'b0, hy_q}) && ({1'b0, hy_q} < py + {1'b0, ch_q});

  // Next-state and registered-output logic for the load / capture / scan sequence
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    rd_all_d = 1'b0;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = err_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    cw_d     = cw_q;
    ch_d     = ch_q;
    ack_d    = 1'b0;
    found_d  = found_q;
    hidx_d   = hidx_q;
    load_go  = 1'b0;
    case (state_q)
      S_IDLE: load_go = bus.load_start;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_CAP;
        idx_d   = '0;
      end
      S_CAP: begin
        if (bus.yx_pos_in == SENT) err_d = 1'b1;
        if (idx_q == num_q - NUM_W'(1)) begin
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_READY;
        end else begin
          idx_d = idx_q + NUM_W'(1);
        end
      end
      S_READY: begin
        // a reload takes precedence over a simultaneous hit request
        if (bus.load_start) begin
          load_go = 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (bus.hit_req) begin
          hx_d    = bus.hit_x;
          hy_d    = bus.hit_y;
          cw_d    = bus.card_w;
          ch_d    = bus.card_h;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (match) begin
          ack_d   = 1'b1;
          found_d = 1'b1;
          hidx_d  = idx_q;
          state_d = S_READY;
        end else if (idx_q == num_q - NUM_W'(1)) begin
          ack_d   = 1'b1;
          found_d = 1'b0;
          hidx_d  = '0;
          state_d = S_READY;
        end else begin
          idx_d = idx_q + NUM_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_go) begin
      if (good_cnt) begin
        num_d    = bus.num_cards_in;
        err_d    = 1'b0;
        rd_all_d = 1'b1;
        state_d  = S_REQ;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Read-back mux: out-of-range reads return the empty marker; a same-cycle capture write wins
  always_comb begin
    rd_yx_d = pos_tbl_q[bus.rd_idx[IDX_W-1:0]];
    if (bus.rd_idx >= num_q)                  rd_yx_d = SENT;
    else if (cap_we && (bus.rd_idx == idx_q)) rd_yx_d = bus.yx_pos_in;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      idx_q    <= '0;
      rd_all_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hx_q     <= '0;
      hy_q     <= '0;
      cw_q     <= '0;
      ch_q     <= '0;
      ack_q    <= 1'b0;
      found_q  <= 1'b0;
      hidx_q   <= '0;
      rd_yx_q  <= SENT;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      rd_all_q <= rd_all_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      cw_q     <= cw_d;
      ch_q     <= ch_d;
      ack_q    <= ack_d;
      found_q  <= found_d;
      hidx_q   <= hidx_d;
      rd_yx_q  <= rd_yx_d;
    end
  end

  // Position table: cleared to empty markers on reset, written one entry per capture cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < MAX_CARDS; e++) pos_tbl_q[e] <= SENT;
    end else if (cap_we) begin
      pos_tbl_q[idx_q[IDX_W-1:0]] <= bus.yx_pos_in;
    end
  end

  assign bus.read_all_positions = rd_all_q;
  assign bus.num_of_cards       = num_q;
  assign bus.layout_valid       = valid_q;
  assign bus.load_done          = done_q;
  assign bus.layout_err         = err_q;
  assign bus.hit_ack            = ack_q;
  assign bus.hit_found          = found_q;
  assign bus.hit_idx            = hidx_q;
  assign bus.rd_yx              = rd_yx_q;

endmodule

// File: tb/tb_card_layout_ctrl.sv
// Directed bench for card_layout_ctrl with a simple position-generator model.
// Checks load timing, table read-back, hit/miss scans, error flags and reset abort.
module tb_card_layout_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_layout_ctrl_if #(.NUM_W(5), .POS_W(20)) ifc ();

  card_layout_ctrl #(.MAX_CARDS(16), .NUM_W(5), .POS_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_vec = 0;
  int n_bad = 0;
  int sent_idx = -1;
  int gn;

  localparam logic [19:0] SENT = 20'hFFFFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Generator layout: 4 columns, row/column pitch chosen per card count
  function automatic logic [19:0] gen_pos(input int n, input int i);
    int col, row, x, y;
    col = i % 4;
    row = i / 4;
    case (n)
      8:       begin x = 100 + 208 * col; y = 100 + 318 * row; end
      12:      begin x = 200 + 208 * col; y = 18 + 250 * row;  end
      default: begin x = 200 + 208 * col; y = 10 + 180 * row;  end
    endcase
    return {y[9:0], x[9:0]};
  endfunction

  // Generator model: one idle cycle after the start pulse is seen, then one position per cycle
  initial begin
    ifc.yx_pos_in = '0;
    forever begin
      @(posedge clk);
      if (ifc.read_all_positions) begin
        gn = int'(ifc.num_of_cards);
        @(posedge clk);
        for (int i = 0; i < gn; i++) begin
          #1 ifc.yx_pos_in = (i == sent_idx) ? SENT : gen_pos(gn, i);
          @(posedge clk);
        end
        #1 ifc.yx_pos_in = '0;
      end
    end
  end

  task automatic do_load(input int num, output int lat, output int pulses, output logic v0);
    ifc.num_cards_in = 5'(num);
    ifc.load_start   = 1'b1;
    tick;
    ifc.load_start = 1'b0;
    lat    = 0;
    pulses = 0;
    v0     = ifc.layout_valid;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) tick;
      if (ifc.read_all_positions) pulses++;
      if (ifc.load_done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_hit(input int x, input int y, input int w, input int h, input bit extra,
                        output int lat, output logic found, output logic [4:0] idx);
    ifc.hit_x   = 10'(x);
    ifc.hit_y   = 10'(y);
    ifc.card_w  = 10'(w);
    ifc.card_h  = 10'(h);
    ifc.hit_req = 1'b1;
    tick;
    ifc.hit_req = 1'b0;
    lat   = 0;
    found = 1'bx;
    idx   = 'x;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (ifc.hit_ack) begin
        lat   = n;
        found = ifc.hit_found;
        idx   = ifc.hit_idx;
        break;
      end
      ifc.hit_req = extra && (n == 3);
    end
    ifc.hit_req = 1'b0;
  endtask

  task automatic rd(input int i, output logic [19:0] v);
    ifc.rd_idx = 5'(i);
    tick;
    v = ifc.rd_yx;
  endtask

  initial begin
    int lat, pulses, acks;
    logic v0, found;
    logic [4:0] idx;
    logic [19:0] v;

    ifc.load_start   = 1'b0;
    ifc.num_cards_in = '0;
    ifc.card_w       = '0;
    ifc.card_h       = '0;
    ifc.hit_req      = 1'b0;
    ifc.hit_x        = '0;
    ifc.hit_y        = '0;
    ifc.rd_idx       = '0;
    repeat (3) tick;
    chk("reset_outs", {ifc.read_all_positions, ifc.num_of_cards, ifc.layout_valid, ifc.load_done,
                       ifc.layout_err, ifc.hit_ack, ifc.hit_found, ifc.hit_idx}, 32'd0);
    chk("reset_rd_yx", ifc.rd_yx, SENT);
    rst = 1'b0;
    tick;

    // easy load of 8 cards
    do_load(8, lat, pulses, v0);
    chk("load8_lat", lat, 10);
    chk("load8_rdall_pulses", pulses, 1);
    chk("load8_err", ifc.layout_err, 0);
    chk("load8_valid", ifc.layout_valid, 1);
    rd(5, v);
    chk("load8_tbl5", v, {10'd418, 10'd308});
    rd(8, v);
    chk("load8_rd_oob", v, SENT);

    // hit on entry 5, then a miss with a dropped second request mid-scan
    do_hit(320, 430, 200, 300, 1'b0, lat, found, idx);
    chk("hit_lat", lat, 6);
    chk("hit_found", found, 1);
    chk("hit_idx", idx, 5);
    do_hit(10, 10, 200, 300, 1'b1, lat, found, idx);
    chk("miss_lat", lat, 8);
    chk("miss_found", found, 0);
    chk("miss_idx", idx, 0);
    acks = 0;
    repeat (20) begin
      tick;
      if (ifc.hit_ack) acks++;
    end
    chk("scan_req_dropped", acks, 0);

    // 16 cards: last-entry hit, edge misses, and a box ending exactly at x=1023
    do_load(16, lat, pulses, v0);
    chk("load16_lat", lat, 18);
    chk("load16_rdall_pulses", pulses, 1);
    do_hit(824, 550, 150, 150, 1'b0, lat, found, idx);
    chk("hard_hit_lat", lat, 16);
    chk("hard_hit_found", found, 1);
    chk("hard_hit_idx", idx, 15);
    do_hit(1023, 700, 150, 150, 1'b0, lat, found, idx);
    chk("hard_miss1_lat", lat, 16);
    chk("hard_miss1_found", found, 0);
    do_hit(824, 700, 150, 150, 1'b0, lat, found, idx);
    chk("hard_miss_ybound", found, 0);
    do_hit(1023, 600, 200, 150, 1'b0, lat, found, idx);
    chk("nowrap_hit_found", found, 1);
    chk("nowrap_hit_idx", idx, 15);

    // bad count from READY: error, no burst, back to IDLE where hits are ignored
    do_load(10, lat, pulses, v0);
    chk("badcnt_rdall_pulses", pulses, 0);
    chk("badcnt_err", ifc.layout_err, 1);
    chk("badcnt_valid", ifc.layout_valid, 0);
    do_hit(320, 430, 200, 300, 1'b0, lat, found, idx);
    chk("idle_hit_ignored", lat, 0);

    // generator emits the error marker on entry 3; load still completes
    sent_idx = 3;
    do_load(8, lat, pulses, v0);
    sent_idx = -1;
    chk("sent_lat", lat, 10);
    chk("sent_err", ifc.layout_err, 1);
    chk("sent_valid", ifc.layout_valid, 1);
    rd(4, v);
    chk("sent_tbl4", v, {10'd418, 10'd100});

    // reset while capturing entry 4 of a 16-card load
    ifc.num_cards_in = 5'd16;
    ifc.load_start   = 1'b1;
    tick;
    ifc.load_start = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    chk("midcap_rst_outs", {ifc.read_all_positions, ifc.num_of_cards, ifc.layout_valid, ifc.load_done,
                            ifc.layout_err, ifc.hit_ack, ifc.hit_found, ifc.hit_idx}, 32'd0);
    chk("midcap_rst_rd_yx", ifc.rd_yx, SENT);
    rst = 1'b0;
    acks = 0;
    repeat (30) begin
      tick;
      if (ifc.load_done || ifc.read_all_positions) acks++;
    end
    chk("midcap_no_done", acks, 0);

    // reload from READY drops layout_valid on the next cycle
    do_load(8, lat, pulses, v0);
    chk("reload8_lat", lat, 10);
    do_load(12, lat, pulses, v0);
    chk("reload12_valid_low", v0, 0);
    chk("reload12_lat", lat, 14);
    chk("reload12_err", ifc.layout_err, 0);
    rd(11, v);
    chk("reload12_tbl11", v, {10'd518, 10'd824});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
